// File: rtl/pixel_stream_gen_pkg.sv
// Shared video definitions for the pixel stream source: default frame geometry,
// FSM state encoding and width helpers.
package pixel_stream_gen_pkg;

    localparam int unsigned VID_DATA_WIDTH = 8;
    localparam int unsigned VID_COLS       = 320;
    localparam int unsigned VID_ROWS       = 240;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VFRONT,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VBACK
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than 1 bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pixel_stream_gen_timing.sv
// Raster timing FSM: frame/row blanking, RAM read addressing and pixel coordinates.
// TEST_PATTERN_EN keeps rd_en low; all other timing is unchanged.
module pixel_stream_timing
    import pixel_stream_gen_pkg::*;
#(
    parameter  int unsigned NO_OF_COLS = VID_COLS,
    parameter  int unsigned NO_OF_ROWS = VID_ROWS,
    parameter  int unsigned HBLANK     = 16,
    parameter  int unsigned VBLANK     = 4,
    localparam int unsigned ADDR_W     = clog2_min1(NO_OF_COLS * NO_OF_ROWS),
    localparam int unsigned CNT_W      = clog2_min1(max3(NO_OF_COLS, HBLANK, VBLANK)),
    localparam int unsigned ROW_W      = clog2_min1(NO_OF_ROWS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              int_fsync,
    output logic              int_rsync,
    output logic [CNT_W-1:0]  col,
    output logic [ROW_W-1:0]  row
);

`ifdef TEST_PATTERN_EN
    localparam bit RD_ACTIVE = 1'b0;
`else
    localparam bit RD_ACTIVE = 1'b1;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_en_q, fsync_q, rsync_q;

    // cnt_q is the column inside ACTIVE and the blank-cycle count elsewhere.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                row_d  = '0;
                addr_d = '0;
                if (start) state_d = ST_VFRONT;
            end
            ST_VFRONT: begin
                if (cnt_q == CNT_W'(VBLANK - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (cnt_q == CNT_W'(NO_OF_COLS - 1)) begin
                    cnt_d = '0;
                    if (row_q == ROW_W'(NO_OF_ROWS - 1)) begin
                        row_d   = '0;
                        addr_d  = '0;
                        state_d = ST_VBACK;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_HBLANK;
                    end
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_HBLANK: begin
                if (cnt_q == CNT_W'(HBLANK - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_VBACK: begin
                if (cnt_q == CNT_W'(VBLANK - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage-0 strobes are decoded from state_d so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            fsync_q <= 1'b0;
            rsync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            rd_en_q <= RD_ACTIVE && (state_d == ST_ACTIVE);
            fsync_q <= (state_d != ST_IDLE);
            rsync_q <= (state_d == ST_ACTIVE);
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = addr_q;
    assign int_fsync = fsync_q;
    assign int_rsync = rsync_q;
    assign col       = cnt_q;
    assign row       = row_q;

endmodule

// File: rtl/pixel_stream_gen.sv
// Frame-to-stream source: timing core plus the 2-stage output pipeline.
// TEST_PATTERN_EN replaces RAM pixels with (col + row) coordinates.
module pixel_stream_gen
    import pixel_stream_gen_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = VID_DATA_WIDTH,
    parameter  int unsigned NO_OF_COLS = VID_COLS,
    parameter  int unsigned NO_OF_ROWS = VID_ROWS,
    parameter  int unsigned HBLANK     = 16,
    parameter  int unsigned VBLANK     = 4,
    localparam int unsigned ADDR_W     = clog2_min1(NO_OF_COLS * NO_OF_ROWS),
    localparam int unsigned CNT_W      = clog2_min1(max3(NO_OF_COLS, HBLANK, VBLANK)),
    localparam int unsigned ROW_W      = clog2_min1(NO_OF_ROWS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  fsync,
    output logic                  rsync,
    output logic [DATA_WIDTH-1:0] pdata_out,
    output logic                  busy,
    output logic                  frame_done
);

    logic                  int_fsync, int_rsync;
    logic [CNT_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic                  fsync1_q, rsync1_q;
    logic                  fsync_q, rsync_q, done_q;
    logic [DATA_WIDTH-1:0] pdata_q, pix_src;

    pixel_stream_timing #(
        .NO_OF_COLS (NO_OF_COLS),
        .NO_OF_ROWS (NO_OF_ROWS),
        .HBLANK     (HBLANK),
        .VBLANK     (VBLANK)
    ) u_timing (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .int_fsync (int_fsync),
        .int_rsync (int_rsync),
        .col       (col),
        .row       (row)
    );

`ifdef TEST_PATTERN_EN
    logic [DATA_WIDTH-1:0] pat1_q;
    logic                  unused_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pat1_q <= '0;
        else        pat1_q <= DATA_WIDTH'(col) + DATA_WIDTH'(row);
    end

    assign pix_src        = pat1_q;
    assign unused_rd_data = ^rd_data;
`else
    logic unused_coords;

    assign pix_src       = rd_data;
    assign unused_coords = ^{col, row};
`endif

    // Stage 1 waits out the RAM read; stage 2 registers the visible outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsync1_q <= 1'b0;
            rsync1_q <= 1'b0;
            fsync_q  <= 1'b0;
            rsync_q  <= 1'b0;
            pdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            fsync1_q <= int_fsync;
            rsync1_q <= int_rsync;
            fsync_q  <= fsync1_q;
            rsync_q  <= rsync1_q;
            done_q   <= fsync_q & ~fsync1_q;
            if (rsync1_q) pdata_q <= pix_src;
        end
    end

    // Spans every cycle where fsync is high anywhere in the pipe, so back-to-back frames keep busy set.
    assign busy       = int_fsync | fsync1_q | fsync_q;
    assign fsync      = fsync_q;
    assign rsync      = rsync_q;
    assign pdata_out  = pdata_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Directed bench for pixel_stream_gen (4x2 frame, HBLANK=2, VBLANK=3).
module tb_pixel_stream_gen;

    localparam int COLS = 4;
    localparam int ROWS = 2;
    localparam int HB   = 2;
    localparam int VB   = 3;
    localparam int DW   = 8;
    localparam int AW   = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          fsync, rsync, busy, frame_done;
    logic [DW-1:0] pdata_out;

    int total = 0;
    int bad   = 0;

    // capture statistics
    int cnt_fsync, cnt_rsync, rd_cnt, fd_cnt, fd_idx, fd_busy_bad;
    int first_fs, first_rs, first_rd, first_addr, max_addr, addr0_cnt;
    int fs_rises, fs_gaps, fs_gap_min, fs_gap_max, fs_low;
    int rs_runs, rs_gap_min, rs_gap_max, rs_low;
    bit fs_seen, rs_seen, fs_prev, rs_prev, busy0;
    logic [DW-1:0] pix[$];

    pixel_stream_gen #(
        .DATA_WIDTH (DW),
        .NO_OF_COLS (COLS),
        .NO_OF_ROWS (ROWS),
        .HBLANK     (HB),
        .VBLANK     (VB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .fsync      (fsync),
        .rsync      (rsync),
        .pdata_out  (pdata_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Frame RAM preset: address i holds 8'h10 + i, one-cycle read latency.
    always @(posedge clk) if (rd_en) rd_data <= 8'h10 + 8'(rd_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int k);
`ifdef TEST_PATTERN_EN
        return 8'((k % COLS) + (k / COLS));
`else
        return 8'(8'h10 + k);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(rd_en), 0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
        chk({tag, "_fsync"}, 32'(fsync), 0);
        chk({tag, "_rsync"}, 32'(rsync), 0);
        chk({tag, "_pdata"}, 32'(pdata_out), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_fdone"}, 32'(frame_done), 0);
    endtask

    // Runs ncyc cycles; start stays high if hold, else pulses after samples p1/p2.
    task automatic run_capture(input int ncyc, input bit hold, input int p1, input int p2);
        cnt_fsync = 0; cnt_rsync = 0; rd_cnt = 0; fd_cnt = 0; fd_idx = -1; fd_busy_bad = 0;
        first_fs = -1; first_rs = -1; first_rd = -1; first_addr = -1; max_addr = 0; addr0_cnt = 0;
        fs_rises = 0; fs_gaps = 0; fs_gap_min = 1000; fs_gap_max = 0; fs_low = 0;
        rs_runs = 0; rs_gap_min = 1000; rs_gap_max = 0; rs_low = 0;
        fs_seen = 0; rs_seen = 0; fs_prev = 0; rs_prev = 0; busy0 = 0;
        pix.delete();
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (i == 0) busy0 = busy;
            if (fsync) begin
                if (!fs_prev) fs_rises++;
                if (fs_seen && fs_low > 0) begin
                    fs_gaps++;
                    if (fs_low < fs_gap_min) fs_gap_min = fs_low;
                    if (fs_low > fs_gap_max) fs_gap_max = fs_low;
                end
                fs_low = 0; fs_seen = 1; cnt_fsync++;
                if (first_fs < 0) first_fs = i;
            end else fs_low++;
            if (rsync) begin
                if (!rs_prev) rs_runs++;
                if (rs_seen && rs_low > 0) begin
                    if (rs_low < rs_gap_min) rs_gap_min = rs_low;
                    if (rs_low > rs_gap_max) rs_gap_max = rs_low;
                end
                rs_low = 0; rs_seen = 1; cnt_rsync++;
                pix.push_back(pdata_out);
                if (first_rs < 0) first_rs = i;
            end else rs_low++;
            if (rd_en) begin
                rd_cnt++;
                if (first_rd < 0) begin first_rd = i; first_addr = int'(rd_addr); end
                if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
                if (rd_addr == 0) addr0_cnt++;
            end
            if (frame_done) begin
                fd_cnt++; fd_idx = i;
                if (busy) fd_busy_bad++;
            end
            fs_prev = fsync; rs_prev = rsync;
            start = hold ? 1'b1 : ((i == p1) || (i == p2));
        end
    endtask

    task automatic check_pixels(input string tag);
        chk({tag, "_npix"}, pix.size(), 8);
        for (int k = 0; k < 8 && k < pix.size(); k++)
            chk($sformatf("%s_pix%0d", tag, k), 32'(pix[k]), 32'(exp_pix(k)));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        #12;
        check_all_zero("reset");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_all_zero("idle");

        // Single frame from one start pulse.
        start = 1'b1;
        run_capture(30, 1'b0, -1, -1);
        chk("t1_busy_accept", 32'(busy0), 1);
        chk("t1_fs_first", first_fs, 2);
        chk("t1_rs_first", first_rs, 5);
`ifdef TEST_PATTERN_EN
        chk("t1_rd_cnt", rd_cnt, 0);
`else
        chk("t1_rd_first", first_rd, 3);
        chk("t1_rd_first_addr", first_addr, 0);
        chk("t1_rd_cnt", rd_cnt, 8);
        chk("t1_max_addr", max_addr, 7);
`endif
        chk("t1_fs_cnt", cnt_fsync, 16);
        chk("t1_rs_cnt", cnt_rsync, 8);
        chk("t1_rs_runs", rs_runs, 2);
        chk("t1_rs_gap_min", rs_gap_min, 2);
        chk("t1_rs_gap_max", rs_gap_max, 2);
        chk("t1_fd_cnt", fd_cnt, 1);
        chk("t1_fd_idx", fd_idx, 18);
        chk("t1_fd_busy", fd_busy_bad, 0);
        check_pixels("t1");
        chk("t1_hold_pdata", 32'(pdata_out), 32'(exp_pix(7)));
        chk("t1_end_busy", 32'(busy), 0);
        chk("t1_end_addr", 32'(rd_addr), 0);

        // start held high: back-to-back frames with a one-cycle fsync gap.
        start = 1'b1;
        run_capture(45, 1'b1, -1, -1);
        start = 1'b0;
        chk("t2_fs_rises", fs_rises, 3);
        chk("t2_fs_gaps", fs_gaps, 2);
        chk("t2_fs_gap_min", fs_gap_min, 1);
        chk("t2_fs_gap_max", fs_gap_max, 1);
        chk("t2_fd_cnt", fd_cnt, 2);
`ifndef TEST_PATTERN_EN
        chk("t2_addr0_cnt", addr0_cnt, 3);
`endif
        for (int i = 0; i < 40; i++) tick();
        chk("t2_drain_fsync", 32'(fsync), 0);
        chk("t2_drain_busy", 32'(busy), 0);

        // start pulses during ACTIVE and VBACK are ignored.
        start = 1'b1;
        run_capture(40, 1'b0, 5, 13);
        chk("t3_fs_rises", fs_rises, 1);
        chk("t3_fs_cnt", cnt_fsync, 16);
        chk("t3_fd_cnt", fd_cnt, 1);
        chk("t3_rs_cnt", cnt_rsync, 8);

        // Asynchronous reset at row 1, column 2.
        start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) start = 1'b0;
        end
`ifndef TEST_PATTERN_EN
        chk("t4_pre_addr", 32'(rd_addr), 6);
`endif
        chk("t4_pre_pdata", 32'(pdata_out), 32'(exp_pix(4)));
        chk("t4_pre_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t4_async");
        tick();
        tick();
        check_all_zero("t4_held");
        rst_n = 1'b1;
        run_capture(10, 1'b0, -1, -1);
        chk("t4_quiet_fs", cnt_fsync, 0);
        chk("t4_quiet_rd", rd_cnt, 0);
        start = 1'b1;
        run_capture(30, 1'b0, -1, -1);
        chk("t4_fs_cnt", cnt_fsync, 16);
        chk("t4_fd_cnt", fd_cnt, 1);
`ifndef TEST_PATTERN_EN
        chk("t4_first_addr", first_addr, 0);
`endif
        check_pixels("t4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_stream_gen.md
Name: pixel_stream_gen

Overview:
Frame-to-stream source for the video pipeline. On a start request it reads one frame from a synchronous-read frame RAM in raster order and emits the fsync/rsync/pdata stream that the line buffers and window filters consume. It inserts programmable vertical and horizontal blanking so that downstream column counters reset and wrap correctly.

Parameters:
DATA_WIDTH, 8, pixel width in bits
NO_OF_COLS, 320, active pixels per row
NO_OF_ROWS, 240, active rows per frame
HBLANK, 16, cycles with rsync low between rows (fsync high), >=1
VBLANK, 4, cycles with fsync high and rsync low before the first row and after the last row, >=1

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  frame request, sampled only in IDLE
rd_en  out  1  frame RAM read enable
rd_addr  out  ADDR_W=$clog2(NO_OF_COLS*NO_OF_ROWS)  frame RAM read address, linear raster
rd_data  in  DATA_WIDTH  RAM read data, valid the cycle after rd_en
fsync  out  1  frame valid
rsync  out  1  row valid / pixel enable
pdata_out  out  DATA_WIDTH  pixel, valid when rsync=1
busy  out  1  high from start acceptance until the last output cycle with fsync=1
frame_done  out  1  one-cycle pulse on the first cycle output fsync is low after a frame

Behaviour:
- Reset (async, rst_n=0): state IDLE; counters 0. rd_en, rd_addr, fsync, rsync, pdata_out, busy and frame_done are all 0 immediately. This applies mid-frame as well, so a frame aborts without completing.
- FSM: IDLE -> VFRONT -> ACTIVE <-> HBLANK ... -> VBACK -> IDLE.
  - IDLE: if start=1, go to VFRONT and set busy.
  - VFRONT: VBLANK cycles, then ACTIVE.
  - ACTIVE: NO_OF_COLS cycles. rd_en=1 and rd_addr increments by 1 each cycle, starting at 0. On the last column: if row==NO_OF_ROWS-1, go to VBACK; otherwise row++ and go to HBLANK.
  - HBLANK: HBLANK cycles, then ACTIVE.
  - VBACK: VBLANK cycles, then IDLE.
- Stage-0 signals (registered): rd_en, rd_addr, int_fsync (state!=IDLE) and int_rsync (state==ACTIVE).
- Stage-1: the RAM returns data. Stage-2 output registers capture rsync, fsync and pdata_out<=rd_data.
  - Latency: rd_en at cycle t gives rsync/pdata_out at cycle t+2.
  - fsync is delayed identically, so its edges stay aligned with rsync.
- pdata_out holds its last value while rsync=0.
- busy clears when output fsync falls. frame_done pulses in that same cycle.
- Minimum gap: IDLE lasts at least 1 cycle, even with start held high, so fsync is low for at least 1 cycle between frames.
- start while not IDLE is ignored. It is neither queued nor an error.
- Frame length in fsync-high cycles: 2*VBLANK + NO_OF_ROWS*NO_OF_COLS + (NO_OF_ROWS-1)*HBLANK.
- rd_addr never exceeds NO_OF_COLS*NO_OF_ROWS-1 and returns to 0 in IDLE.
- Column and blank counters are sized with $clog2 of the larger of the counts they hold.

Optional Feature:
TEST_PATTERN_EN
- Defined: rd_en stays 0 and rd_data is ignored. pdata_out = (col + row) truncated to DATA_WIDTH, where col/row are the pixel's coordinates, carried through the same 2-stage pipeline. Timing is identical.
- Undefined: pixels come from rd_data as specified above.

Decomposition:
- Shared video package: DATA_WIDTH default, frame-size constants (NO_OF_COLS/NO_OF_ROWS), and the FSM state encoding (IDLE, VFRONT, ACTIVE, HBLANK, VBACK).
- One sub-module: pixel_stream_timing. It holds the FSM and counters, and produces int_fsync/int_rsync/rd_en/rd_addr/col/row.
- The top level adds the 2-stage output pipeline and pattern mux.

Test Plan:
- COLS=4, ROWS=2, HBLANK=2, VBLANK=3, RAM preset addr i -> data 8'h10+i; one start pulse.
  - rsync high for 2 runs of 4 cycles, separated by 2 low cycles.
  - pdata_out = 10,11,12,13 then 14,15,16,17.
  - fsync high exactly 16 cycles; frame_done pulses once.
- Same config, rd_en first high at cycle t -> rsync first high at t+2; fsync rises at (first rd_en) - 3 + 2.
- start held high continuously -> back-to-back frames with fsync low exactly 1 cycle between them; rd_addr restarts at 0.
- start pulses during ACTIVE and VBACK -> ignored; exactly one frame produced.
- rst_n low during row 1, column 2 -> all outputs 0 asynchronously. After release: no activity until start; the next frame is complete from addr 0.
- TEST_PATTERN_EN defined -> rd_en never high; row0 pdata = 0,1,2,3; row1 pdata = 1,2,3,4.
